// File: rtl/tinygpu_pc_pkg.sv
// Shared definitions for the per-thread PC/NZP unit: FSM states and flag bit positions.
package tinygpu_pc_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, UPDATE} state_t;

  // Flag positions on the ALU result bus
  localparam int FLAG_N_BIT = 0;
  localparam int FLAG_Z_BIT = 1;
  localparam int FLAG_P_BIT = 2;

  // Field positions in the {N,Z,P} register
  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;
endpackage

// File: rtl/nzp_flag_unpack.sv
// Maps packed ALU comparison flags to {N,Z,P} and flags values that are not a clean one-hot code.
module nzp_flag_unpack
  import tinygpu_pc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_alu,
  output logic [2:0]       o_nzp,
  output logic             o_malformed
);
  logic w_upper;
  logic w_onehot;

  generate
    if (WIDTH > 3) begin : g_upper
      assign w_upper = |i_alu[WIDTH-1:3];
    end else begin : g_no_upper
      assign w_upper = 1'b0;
    end
  endgenerate

  always_comb begin
    o_nzp        = 3'b000;
    o_nzp[NZP_N] = i_alu[FLAG_N_BIT];
    o_nzp[NZP_Z] = i_alu[FLAG_Z_BIT];
    o_nzp[NZP_P] = i_alu[FLAG_P_BIT];
  end

  assign w_onehot    = (i_alu[2:0] == 3'b001) || (i_alu[2:0] == 3'b010) ||
                       (i_alu[2:0] == 3'b100);
  assign o_malformed = w_upper | ~w_onehot;
endmodule

// File: rtl/pc_nzp_unit.sv
// Per-thread NZP flag register, BRnzp evaluation and next-PC generation via IDLE/EVAL/UPDATE.
module pc_nzp_unit
  import tinygpu_pc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PC_WIDTH  = 8,
  parameter int IMM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Enable,
  input  logic                 InstValid,
  output logic                 InstReady,
  input  logic                 NZPWriteEn,
  input  logic                 BranchEn,
  input  logic [2:0]           BranchCond,
  input  logic [IMM_WIDTH-1:0] BranchImm,
  input  logic [PC_WIDTH-1:0]  CurrentPC,
  input  logic [WIDTH-1:0]     ALUOut,
  output logic [PC_WIDTH-1:0]  NextPC,
  output logic                 NextPCValid,
  output logic                 BranchTaken,
  output logic [2:0]           NZP,
  output logic                 FlagErr
);
  state_t               r_state;
  logic                 r_we;
  logic                 r_be;
  logic [2:0]           r_cond;
  logic [IMM_WIDTH-1:0] r_imm;
  logic [PC_WIDTH-1:0]  r_pc;

  logic [2:0]           w_nzp;
  logic                 w_malformed;
  logic                 w_taken;

  nzp_flag_unpack #(.WIDTH(WIDTH)) u_unpack (
    .i_alu       (ALUOut),
    .o_nzp       (w_nzp),
    .o_malformed (w_malformed)
  );

  assign InstReady = (r_state == IDLE) & Enable & rst_n;

  // A CMP that also has BranchEn set never branches; condition uses the pre-write NZP.
  assign w_taken = ~r_we & r_be & |(r_cond & NZP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_be        <= 1'b0;
      r_cond      <= 3'b000;
      r_imm       <= '0;
      r_pc        <= '0;
      NZP         <= 3'b000;
      NextPC      <= '0;
      NextPCValid <= 1'b0;
      BranchTaken <= 1'b0;
      FlagErr     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          NextPCValid <= 1'b0;
          if (InstValid && InstReady) begin
            r_we    <= NZPWriteEn;
            r_be    <= BranchEn;
            r_cond  <= BranchCond;
            r_imm   <= BranchImm;
            r_pc    <= CurrentPC;
            r_state <= EVAL;
          end
        end
        EVAL: begin
          if (!Enable) begin
            NextPCValid <= 1'b0;
            r_state     <= IDLE;
          end else begin
            if (r_we) begin
              NZP     <= w_nzp;
              FlagErr <= FlagErr | w_malformed;
            end
            BranchTaken <= w_taken;
            NextPC      <= w_taken ? PC_WIDTH'(r_imm) : r_pc + PC_WIDTH'(1);
            NextPCValid <= 1'b1;
            r_state     <= UPDATE;
          end
        end
        UPDATE: begin
          NextPCValid <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          NextPCValid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_nzp_unit.sv
// Directed bench for pc_nzp_unit: hand-computed vectors sampled on the falling edge.
module tb_pc_nzp_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       Enable;
  logic       InstValid;
  logic       InstReady;
  logic       NZPWriteEn;
  logic       BranchEn;
  logic [2:0] BranchCond;
  logic [7:0] BranchImm;
  logic [7:0] CurrentPC;
  logic [7:0] ALUOut;
  logic [7:0] NextPC;
  logic       NextPCValid;
  logic       BranchTaken;
  logic [2:0] NZP;
  logic       FlagErr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_nzp_unit #(.WIDTH(8), .PC_WIDTH(8), .IMM_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .Enable(Enable), .InstValid(InstValid),
    .InstReady(InstReady), .NZPWriteEn(NZPWriteEn), .BranchEn(BranchEn),
    .BranchCond(BranchCond), .BranchImm(BranchImm), .CurrentPC(CurrentPC),
    .ALUOut(ALUOut), .NextPC(NextPC), .NextPCValid(NextPCValid),
    .BranchTaken(BranchTaken), .NZP(NZP), .FlagErr(FlagErr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction and check the full accept -> EVAL -> UPDATE -> IDLE sequence.
  task automatic run_inst(input string tag, input logic we, input logic be,
                          input logic [2:0] cond, input logic [7:0] imm,
                          input logic [7:0] pc, input logic [7:0] alu,
                          input logic [7:0] exp_pc, input logic exp_tk,
                          input logic [2:0] exp_nzp, input logic exp_err);
    @(negedge clk);
    chk({tag, ".ready"}, InstReady, 1'b1);
    NZPWriteEn = we; BranchEn = be; BranchCond = cond;
    BranchImm = imm; CurrentPC = pc; ALUOut = alu; InstValid = 1'b1;
    @(negedge clk);
    InstValid = 1'b0;
    chk({tag, ".eval_vld"}, NextPCValid, 1'b0);
    @(negedge clk);
    chk({tag, ".vld"}, NextPCValid, 1'b1);
    chk({tag, ".pc"}, NextPC, exp_pc);
    chk({tag, ".tk"}, BranchTaken, exp_tk);
    chk({tag, ".nzp"}, NZP, exp_nzp);
    chk({tag, ".err"}, FlagErr, exp_err);
    @(negedge clk);
    chk({tag, ".post_vld"}, NextPCValid, 1'b0);
    chk({tag, ".hold_pc"}, NextPC, exp_pc);
  endtask

  initial begin
    logic [6:0] rdy_pat;
    rst_n = 1'b0; Enable = 1'b1; InstValid = 1'b0; NZPWriteEn = 1'b0;
    BranchEn = 1'b0; BranchCond = 3'b000; BranchImm = 8'h00;
    CurrentPC = 8'h00; ALUOut = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst.ready", InstReady, 1'b0);
    chk("rst.nzp", NZP, 3'b000);
    chk("rst.vld", NextPCValid, 1'b0);
    chk("rst.err", FlagErr, 1'b0);
    chk("rst.pc", NextPC, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel.ready", InstReady, 1'b1);

    run_inst("br_reset", 0, 1, 3'b111, 8'h40, 8'h01, 8'h00, 8'h02, 0, 3'b000, 0);
    run_inst("cmp_z",    1, 0, 3'b000, 8'h00, 8'h05, 8'h02, 8'h06, 0, 3'b010, 0);
    run_inst("br_take",  0, 1, 3'b011, 8'h20, 8'h06, 8'h00, 8'h20, 1, 3'b010, 0);
    run_inst("br_not",   0, 1, 3'b100, 8'h20, 8'h06, 8'h00, 8'h07, 0, 3'b010, 0);
    run_inst("br_c000",  0, 1, 3'b000, 8'h30, 8'h10, 8'h00, 8'h11, 0, 3'b010, 0);
    run_inst("br_c111",  0, 1, 3'b111, 8'h31, 8'h10, 8'h00, 8'h31, 1, 3'b010, 0);
    run_inst("wrap",     0, 0, 3'b111, 8'h55, 8'hFF, 8'h04, 8'h00, 0, 3'b010, 0);
    run_inst("both",     1, 1, 3'b111, 8'h44, 8'h20, 8'h01, 8'h21, 0, 3'b100, 0);
    run_inst("bad_up",   1, 0, 3'b000, 8'h00, 8'h30, 8'h09, 8'h31, 0, 3'b100, 1);
    run_inst("good_cmp", 1, 0, 3'b000, 8'h00, 8'h31, 8'h04, 8'h32, 0, 3'b001, 1);
    run_inst("br_p",     0, 1, 3'b001, 8'h77, 8'h32, 8'h00, 8'h77, 1, 3'b001, 1);

    // Enable dropped during EVAL of a CMP that would have written N
    @(negedge clk);
    NZPWriteEn = 1'b1; BranchEn = 1'b0; CurrentPC = 8'h40; ALUOut = 8'h01;
    InstValid = 1'b1;
    @(negedge clk);
    InstValid = 1'b0; Enable = 1'b0;
    @(negedge clk);
    chk("abort.vld", NextPCValid, 1'b0);
    chk("abort.nzp", NZP, 3'b001);
    chk("abort.ready_off", InstReady, 1'b0);
    Enable = 1'b1;
    #1 chk("abort.idle", InstReady, 1'b1);
    @(negedge clk);
    chk("abort.vld2", NextPCValid, 1'b0);
    chk("abort.pc", NextPC, 8'h77);

    // Back-to-back InstValid: accepted only every third edge
    NZPWriteEn = 1'b0; BranchEn = 1'b0; CurrentPC = 8'h50; ALUOut = 8'h00;
    InstValid = 1'b1;
    rdy_pat = '0;
    for (int i = 0; i < 7; i++) begin
      rdy_pat[i] = InstReady;
      @(negedge clk);
    end
    InstValid = 1'b0;
    chk("b2b.pattern", rdy_pat, 7'b1001001);
    repeat (2) @(negedge clk);

    // Reset asserted while a taken branch is in UPDATE
    chk("pre_rst.ready", InstReady, 1'b1);
    BranchEn = 1'b1; BranchCond = 3'b111; BranchImm = 8'h33; CurrentPC = 8'h10;
    InstValid = 1'b1;
    @(negedge clk);
    InstValid = 1'b0;
    @(negedge clk);
    chk("upd.vld", NextPCValid, 1'b1);
    chk("upd.tk", BranchTaken, 1'b1);
    chk("upd.pc", NextPC, 8'h33);
    rst_n = 1'b0;
    #1;
    chk("mrst.vld", NextPCValid, 1'b0);
    chk("mrst.tk", BranchTaken, 1'b0);
    chk("mrst.pc", NextPC, 8'h00);
    chk("mrst.nzp", NZP, 3'b000);
    chk("mrst.err", FlagErr, 1'b0);
    chk("mrst.ready", InstReady, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_inst("post_br",  0, 1, 3'b111, 8'h66, 8'h08, 8'h00, 8'h09, 0, 3'b000, 0);
    run_inst("bad_oh",   1, 0, 3'b000, 8'h00, 8'h09, 8'h03, 8'h0A, 0, 3'b110, 1);
    run_inst("sticky",   1, 0, 3'b000, 8'h00, 8'h0A, 8'h02, 8'h0B, 0, 3'b010, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
